// File: rtl/copy_fanout.sv
// Packet copy fan-out stage: captures one packet from a 4-phase upstream
// handshake and emits 1..8 copies downstream with incrementing destinations.
module copy_fanout #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          MR,
  input  logic          Send_in,
  output logic          Ack_out,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] dst_in,
  input  logic [2:0]    ncpy_in,
  input  logic          cpy,
  input  logic          exb,
  output logic          Send_out,
  input  logic          Ack_in,
  output logic [DW-1:0] data_out,
  output logic [AW-1:0] dst_out,
  output logic          last_out,
  output logic          CP,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RTZ  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic [2:0]    last_idx_reg;
  logic [DW-1:0] data_reg;
  logic [AW-1:0] dst_reg;
  logic          ack_reg, ack_next;
  logic          cp_reg;
  logic          capture;

  // A new packet is only accepted once the previous upstream handshake has
  // fully returned to zero and no copies are outstanding.
  assign capture = (state_reg == IDLE) && !ack_reg && Send_in;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ack_next   = ack_reg;

    if (capture) begin
      ack_next = 1'b1;
      if (!exb) begin
        state_next = SEND;
        idx_next   = 3'd0;
      end
    end else if (ack_reg && !Send_in) begin
      ack_next = 1'b0;
    end

    case (state_reg)
      SEND: begin
        if (Ack_in) state_next = RTZ;
      end
      RTZ: begin
        if (!Ack_in) begin
          if (idx_reg == last_idx_reg) begin
            state_next = IDLE;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = SEND;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state_reg    <= IDLE;
      idx_reg      <= 3'd0;
      last_idx_reg <= 3'd0;
      data_reg     <= '0;
      dst_reg      <= '0;
      ack_reg      <= 1'b0;
      cp_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ack_reg   <= ack_next;
      cp_reg    <= capture;
      if (capture) begin
        data_reg     <= data_in;
        dst_reg      <= dst_in;
        last_idx_reg <= cpy ? ncpy_in : 3'd0;
      end
    end
  end

  // Destination wraps naturally in AW bits.
  assign dst_out  = dst_reg + AW'(idx_reg);
  assign data_out = data_reg;
  assign Send_out = (state_reg == SEND);
  assign busy     = (state_reg != IDLE);
  assign last_out = busy && (idx_reg == last_idx_reg);
  assign Ack_out  = ack_reg;
  assign CP       = cp_reg;

endmodule

// File: tb/tb_copy_fanout.sv
// Directed bench for copy_fanout: hand-computed expectations per clock cycle.
module tb_copy_fanout;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          MR = 1'b1;
  logic          Send_in = 1'b0;
  logic          Ack_out;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] dst_in = '0;
  logic [2:0]    ncpy_in = '0;
  logic          cpy = 1'b0;
  logic          exb = 1'b0;
  logic          Send_out;
  logic          Ack_in = 1'b0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] dst_out;
  logic          last_out;
  logic          CP;
  logic          busy;

  int errors = 0;
  int checks = 0;

  copy_fanout #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .MR(MR), .Send_in(Send_in), .Ack_out(Ack_out),
    .data_in(data_in), .dst_in(dst_in), .ncpy_in(ncpy_in), .cpy(cpy),
    .exb(exb), .Send_out(Send_out), .Ack_in(Ack_in), .data_out(data_out),
    .dst_out(dst_out), .last_out(last_out), .CP(CP), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".send_out"}, 32'(Send_out), 32'd0);
    check({tag, ".ack_out"},  32'(Ack_out),  32'd0);
    check({tag, ".cp"},       32'(CP),       32'd0);
    check({tag, ".busy"},     32'(busy),     32'd0);
    check({tag, ".last"},     32'(last_out), 32'd0);
    check({tag, ".data"},     32'(data_out), 32'd0);
    check({tag, ".dst"},      32'(dst_out),  32'd0);
  endtask

  // Expects SEND on entry; completes one downstream 4-phase handshake.
  task automatic do_copy(input string tag, input logic [DW-1:0] exp_data,
                         input logic [AW-1:0] exp_dst, input logic exp_last);
    check({tag, ".send_out"}, 32'(Send_out), 32'd1);
    check({tag, ".data"},     32'(data_out), 32'(exp_data));
    check({tag, ".dst"},      32'(dst_out),  32'(exp_dst));
    check({tag, ".last"},     32'(last_out), 32'(exp_last));
    Ack_in = 1'b1;
    tick();
    check({tag, ".rtz_send"}, 32'(Send_out), 32'd0);
    check({tag, ".rtz_dst"},  32'(dst_out),  32'(exp_dst));
    Ack_in = 1'b0;
    tick();
  endtask

  task automatic launch(input logic [DW-1:0] d, input logic [AW-1:0] a,
                        input logic c, input logic [2:0] n, input logic x);
    data_in = d; dst_in = a; cpy = c; ncpy_in = n; exb = x;
    Send_in = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    MR = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    MR = 1'b0;

    // Single pass-through
    launch(16'hA5A5, 8'h10, 1'b0, 3'd5, 1'b0);
    check("pass.cp",    32'(CP),       32'd1);
    check("pass.ack",   32'(Ack_out),  32'd1);
    check("pass.busy",  32'(busy),     32'd1);
    Send_in = 1'b0;
    do_copy("pass.c0", 16'hA5A5, 8'h10, 1'b1);
    check("pass.cp_once", 32'(CP),      32'd0);
    check("pass.ack_rtz", 32'(Ack_out), 32'd0);
    check("pass.idle",    32'(busy),    32'd0);
    check("pass.last_idle", 32'(last_out), 32'd0);

    // Wrap fan-out
    launch(16'h1234, 8'hFE, 1'b1, 3'd3, 1'b0);
    check("wrap.cp", 32'(CP), 32'd1);
    Send_in = 1'b0;
    do_copy("wrap.c0", 16'h1234, 8'hFE, 1'b0);
    do_copy("wrap.c1", 16'h1234, 8'hFF, 1'b0);
    do_copy("wrap.c2", 16'h1234, 8'h00, 1'b0);
    do_copy("wrap.c3", 16'h1234, 8'h01, 1'b1);
    check("wrap.idle", 32'(busy), 32'd0);
    check("wrap.send_idle", 32'(Send_out), 32'd0);

    // Extinguish
    launch(16'h5555, 8'h33, 1'b1, 3'd2, 1'b1);
    check("exb.cp",   32'(CP),       32'd1);
    check("exb.ack",  32'(Ack_out),  32'd1);
    check("exb.send", 32'(Send_out), 32'd0);
    check("exb.busy", 32'(busy),     32'd0);
    tick();
    check("exb.no_recap", 32'(CP),      32'd0);
    check("exb.ack_hold", 32'(Ack_out), 32'd1);
    Send_in = 1'b0;
    tick();
    check("exb.ack_fall", 32'(Ack_out),  32'd0);
    check("exb.send2",    32'(Send_out), 32'd0);
    check("exb.busy2",    32'(busy),     32'd0);
    exb = 1'b0;

    // Stalled downstream with a second request held high
    launch(16'hBEEF, 8'h20, 1'b1, 3'd1, 1'b0);
    Send_in = 1'b0;
    tick();
    check("stall.ack_fall", 32'(Ack_out), 32'd0);
    data_in = 16'h1111; dst_in = 8'h40; cpy = 1'b0; ncpy_in = 3'd6;
    Send_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("stall.send[%0d]", i), 32'(Send_out), 32'd1);
      check($sformatf("stall.data[%0d]", i), 32'(data_out), 32'h0000BEEF);
      check($sformatf("stall.dst[%0d]", i),  32'(dst_out),  32'h20);
      check($sformatf("stall.cp[%0d]", i),   32'(CP),       32'd0);
    end
    Ack_in = 1'b1;
    tick();
    check("stall.rtz", 32'(Send_out), 32'd0);
    Ack_in = 1'b0;
    tick();
    check("stall.cp_c1", 32'(CP), 32'd0);
    do_copy("stall.c1", 16'hBEEF, 8'h21, 1'b1);
    check("stall.idle_nocp", 32'(CP),   32'd0);
    check("stall.idle",      32'(busy), 32'd0);
    tick();
    check("stall.second_cp", 32'(CP),      32'd1);
    check("stall.second_ack", 32'(Ack_out), 32'd1);
    Send_in = 1'b0;
    do_copy("stall.p2", 16'h1111, 8'h40, 1'b1);
    check("stall.p2_idle", 32'(busy), 32'd0);

    // Ack_in ignored in IDLE, then early Ack at SEND entry
    Ack_in = 1'b1;
    tick();
    check("early.idle_ignore", 32'(busy), 32'd0);
    launch(16'h7777, 8'h55, 1'b0, 3'd0, 1'b0);
    check("early.send", 32'(Send_out), 32'd1);
    check("early.dst",  32'(dst_out),  32'h55);
    Send_in = 1'b0;
    tick();
    check("early.send_drop", 32'(Send_out), 32'd0);
    check("early.rtz_busy",  32'(busy),     32'd1);
    tick();
    check("early.rtz_hold", 32'(Send_out), 32'd0);
    check("early.rtz_hold_busy", 32'(busy), 32'd1);
    Ack_in = 1'b0;
    tick();
    check("early.idle", 32'(busy), 32'd0);

    // Reset mid-packet, then reset colliding with a capture
    launch(16'hCAFE, 8'h80, 1'b1, 3'd7, 1'b0);
    Send_in = 1'b0;
    do_copy("rst.c0", 16'hCAFE, 8'h80, 1'b0);
    check("rst.c1_send", 32'(Send_out), 32'd1);
    check("rst.c1_dst",  32'(dst_out),  32'h81);
    MR = 1'b1;
    tick();
    check_all_zero("rst.mid");
    data_in = 16'h4242; dst_in = 8'h90; cpy = 1'b1; ncpy_in = 3'd1;
    Send_in = 1'b1;
    tick();
    check_all_zero("rst.prio");
    MR = 1'b0;
    tick();
    check("rst.fresh_cp", 32'(CP), 32'd1);
    Send_in = 1'b0;
    do_copy("rst.f0", 16'h4242, 8'h90, 1'b0);
    do_copy("rst.f1", 16'h4242, 8'h91, 1'b1);
    check("rst.fresh_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/copy_fanout.md
COPY_FANOUT -- requirements
Module: copy_fanout

Interface
REQ-001 SHALL have parameter DW, default 16: packet data width.
REQ-002 SHALL have parameter AW, default 8: destination node-number width.
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port MR, input, 1: master reset, synchronous, active-high.
REQ-005 SHALL have port Send_in, input, 1: upstream request, 4-phase level.
REQ-006 SHALL have port Ack_out, output, 1: upstream acknowledge, 4-phase level.
REQ-007 SHALL have port data_in, input, DW: packet data, valid while Send_in=1.
REQ-008 SHALL have port dst_in, input, AW: base destination node.
REQ-009 SHALL have port ncpy_in, input, 3: copies minus one (0..7 = 1..8 copies).
REQ-010 SHALL have port cpy, input, 1: copy enable; 0 = single pass-through.
REQ-011 SHALL have port exb, input, 1: extinguish bit; 1 = packet consumed, nothing emitted.
REQ-012 SHALL have port Send_out, output, 1: downstream request, 4-phase level.
REQ-013 SHALL have port Ack_in, input, 1: downstream acknowledge, 4-phase level.
REQ-014 SHALL have port data_out, output, DW: copy data.
REQ-015 SHALL have port dst_out, output, AW: copy destination.
REQ-016 SHALL have port last_out, output, 1: current copy is final copy of packet.
REQ-017 SHALL have port CP, output, 1: one-cycle capture pulse.
REQ-018 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, SEND (Send_out=1, await Ack_in=1), RTZ (Send_out=0, await Ack_in=0).
REQ-020 SHALL capture data_in, dst_in, ncpy_in, cpy, exb only when, in IDLE, Ack_out=0 and Send_in=1 are sampled; CP=1 for exactly the following cycle.
REQ-021 SHALL raise Ack_out the cycle after capture and hold it until Send_in=0 is sampled, clearing it the next cycle.
REQ-022 SHALL not capture again while Ack_out=1 or state is not IDLE; Send_in is ignored then.
REQ-023 SHALL, on capture with exb=0, enter SEND next cycle with copy index 0 and Send_out=1.
REQ-024 SHALL, on capture with exb=1, stay in IDLE and emit no Send_out (Ack_out handshake still completes).
REQ-025 SHALL use effective count N = ncpy_in+1 when cpy=1, N = 1 when cpy=0.
REQ-026 SHALL, in SEND with Ack_in=1 sampled, deassert Send_out next cycle and go to RTZ; Send_out is held at least one cycle even if Ack_in is already high.
REQ-027 SHALL, in RTZ with Ack_in=0 sampled: if index = N-1, go IDLE; else increment index, reassert Send_out next cycle, go SEND.
REQ-028 SHALL drive data_out = captured data, dst_out = (captured dst + index) mod 2^AW, last_out = (index = N-1); all stable from Send_out rise until Ack_in=0 seen in RTZ.
REQ-029 SHALL ignore Ack_in in IDLE.
REQ-030 SHALL allow upstream return-to-zero (Ack_out fall) to overlap downstream copy emission.

Reset
REQ-031 SHALL, when MR=1 sampled, set next cycle: state IDLE, index 0, Send_out=0, Ack_out=0, CP=0, busy=0, last_out=0, data_out=0, dst_out=0.
REQ-032 SHALL give MR priority over every other event, including a simultaneous capture; reset mid-packet drops remaining copies.

Verification
REQ-033 Single pass-through: cpy=0, data 0xA5A5, dst 0x10, Send_in=1 -> CP pulse, Ack_out=1, one Send_out with dst_out=0x10, last_out=1; busy falls after Ack_in returns 0.
REQ-034 Wrap fan-out: cpy=1, ncpy=3, dst 0xFE -> four copies, dst_out 0xFE,0xFF,0x00,0x01; last_out=1 only on 0x01.
REQ-035 Extinguish: exb=1, Send_in=1 -> Ack_out rises then falls after Send_in=0; Send_out stays 0, busy stays 0.
REQ-036 Stalled downstream: ncpy=1, Ack_in held 0 for 20 cycles -> Send_out held 1, data/dst stable; second Send_in held high not captured (no CP) until IDLE and Ack_out=0.
REQ-037 Early Ack: Ack_in already 1 at SEND entry -> Send_out=1 for exactly one cycle, then RTZ.
REQ-038 Reset mid-packet: MR=1 during copy 2 of 8 -> next cycle all outputs 0, IDLE; fresh packet afterwards starts at index 0.
